// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment bus reader: segment codes, bit positions,
// FSM state encoding and the lookup result payload.
package seg7_pkg;

  // Segment byte layout {a,b,c,d,e,f,g,dp}, active-high
  localparam int unsigned SEG_BIT_A  = 7;
  localparam int unsigned SEG_BIT_G  = 1;
  localparam int unsigned SEG_BIT_DP = 0;
  localparam int unsigned PAT_W      = SEG_BIT_A - SEG_BIT_G + 1;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned NUM_CODES  = 16;

  // Hex glyphs as driven on the bus, dp bit clear
  localparam logic [7:0] SEG_0 = 8'hFC;
  localparam logic [7:0] SEG_1 = 8'h60;
  localparam logic [7:0] SEG_2 = 8'hDA;
  localparam logic [7:0] SEG_3 = 8'hF2;
  localparam logic [7:0] SEG_4 = 8'h66;
  localparam logic [7:0] SEG_5 = 8'hB6;
  localparam logic [7:0] SEG_6 = 8'hBE;
  localparam logic [7:0] SEG_7 = 8'hE0;
  localparam logic [7:0] SEG_8 = 8'hFE;
  localparam logic [7:0] SEG_9 = 8'hF6;
  localparam logic [7:0] SEG_A = 8'hEE;
  localparam logic [7:0] SEG_B = 8'h3E;
  localparam logic [7:0] SEG_C = 8'h1A;
  localparam logic [7:0] SEG_D = 8'h7A;
  localparam logic [7:0] SEG_E = 8'h9E;
  localparam logic [7:0] SEG_F = 8'h8E;

  // Indexed by nibble value: SEG_TABLE[n] is the glyph for n
  localparam logic [NUM_CODES-1:0][7:0] SEG_TABLE = {
    SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
    SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };

  // Stability tracker states
  localparam int unsigned ST_W     = 2;
  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_COUNT = 2'd1;
  localparam logic [1:0]  ST_HELD  = 2'd2;

  // Result of a pattern -> nibble decode
  typedef struct packed {
    logic             hit;
    logic [NIB_W-1:0] nibble;
  } lookup_t;

endpackage

// File: rtl/seg7_pattern_lookup.sv
// Combinational reverse decode of a 7-segment pattern (dp excluded) to a hex nibble.
module seg7_pattern_lookup
  import seg7_pkg::*;
(
  input  logic [PAT_W-1:0] pattern,
  output lookup_t          result_c
);

  // Linear search over the glyph table; glyphs are unique so at most one hits
  always_comb begin
    logic             hit;
    logic [NIB_W-1:0] nibble;
    hit    = 1'b0;
    nibble = '0;
    for (int i = 0; i < int'(NUM_CODES); i++) begin
      if (!hit && pattern == SEG_TABLE[i][SEG_BIT_A:SEG_BIT_G]) begin
        hit    = 1'b1;
        nibble = NIB_W'(i);
      end
    end
    result_c.hit    = hit;
    result_c.nibble = nibble;
  end

endmodule

// File: rtl/seg7_capture.sv
// Monitor for a multiplexed 7-segment display bus. Synchronises the segment and
// digit-select lines, waits for a pattern to be stable, decodes it back to a hex
// nibble and keeps one captured register per digit position.
// Optional build macro: SEG7_CAP_BLANK_EN (all-segments-off commits as a blank
// digit instead of raising the error flag).
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dsel_in,
  input  logic                    clr,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   dp_out,
  output logic [NUM_DIGITS-1:0]   valid_out,
  output logic                    err_out,
  output logic                    update_pulse
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [NUM_DIGITS-1:0] DSEL_ONE   = NUM_DIGITS'(1);
  localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(STABLE_CYCLES - 1);
  localparam logic                  COMMIT_NOW = (STABLE_CYCLES == 1);

  logic [7:0]            seg_meta, s_seg, prev_seg;
  logic [NUM_DIGITS-1:0] dsel_meta, s_dsel, prev_dsel;
  logic                  match_c, onehot_c;

  logic [ST_W-1:0]  state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             commit_c, commit_q;

  logic [ST_W-1:0]  entry_state_c;
  logic [CNT_W-1:0] entry_cnt_c;
  logic             entry_commit_c;

  logic [IDX_W-1:0] idx_c;
  lookup_t          lookup_c;

  // Two-flop synchronisers for the asynchronous display bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_meta  <= '0;
      s_seg     <= '0;
      dsel_meta <= '0;
      s_dsel    <= '0;
    end else begin
      seg_meta  <= seg_in;
      s_seg     <= seg_meta;
      dsel_meta <= dsel_in;
      s_dsel    <= dsel_meta;
    end
  end

  // Previous-sample register; also holds the committed sample for the capture stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_seg  <= '0;
      prev_dsel <= '0;
    end else begin
      prev_seg  <= s_seg;
      prev_dsel <= s_dsel;
    end
  end

  assign match_c  = ({s_seg, s_dsel} == {prev_seg, prev_dsel});
  assign onehot_c = (s_dsel != '0) && ((s_dsel & (s_dsel - DSEL_ONE)) == '0);

  // Fresh-interval evaluation shared by IDLE and a change seen while HELD
  always_comb begin
    entry_state_c  = ST_IDLE;
    entry_cnt_c    = '0;
    entry_commit_c = 1'b0;
    if (onehot_c) begin
      if (COMMIT_NOW) begin
        entry_state_c  = ST_HELD;
        entry_commit_c = 1'b1;
      end else begin
        entry_state_c = ST_COUNT;
        entry_cnt_c   = CNT_W'(1);
      end
    end
  end

  // FSM state and stability counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: one commit per stable interval, counter saturates at the commit point
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        state_nxt = entry_state_c;
        cnt_nxt   = entry_cnt_c;
        commit_c  = entry_commit_c;
      end
      ST_COUNT: begin
        if (!onehot_c) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (!match_c) begin
          cnt_nxt = CNT_W'(1);
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_HELD;
          cnt_nxt   = '0;
          commit_c  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_HELD: begin
        if (!match_c) begin
          state_nxt = entry_state_c;
          cnt_nxt   = entry_cnt_c;
          commit_c  = entry_commit_c;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
    if (clr) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      commit_c  = 1'b0;
    end
  end

  // One-hot digit select of the committed sample to a digit index
  always_comb begin
    idx_c = '0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (prev_dsel[k]) idx_c = IDX_W'(k);
    end
  end

  seg7_pattern_lookup u_lookup (
    .pattern  (prev_seg[SEG_BIT_A:SEG_BIT_G]),
    .result_c (lookup_c)
  );

  // Capture stage: applies a commit to the selected digit one cycle after the decision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_q     <= 1'b0;
      update_pulse <= 1'b0;
      digits_out   <= '0;
      dp_out       <= '0;
      valid_out    <= '0;
      err_out      <= 1'b0;
    end else if (clr) begin
      commit_q     <= 1'b0;
      update_pulse <= 1'b0;
      digits_out   <= '0;
      dp_out       <= '0;
      valid_out    <= '0;
      err_out      <= 1'b0;
    end else begin
      commit_q     <= commit_c;
      update_pulse <= commit_q;
      if (commit_q) begin
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
          if (idx_c == IDX_W'(k)) begin
            if (lookup_c.hit) begin
              digits_out[4*k +: 4] <= lookup_c.nibble;
              dp_out[k]            <= prev_seg[SEG_BIT_DP];
              valid_out[k]         <= 1'b1;
            end
`ifdef SEG7_CAP_BLANK_EN
            else if (prev_seg[SEG_BIT_A:SEG_BIT_G] == '0) begin
              digits_out[4*k +: 4] <= '0;
              dp_out[k]            <= prev_seg[SEG_BIT_DP];
              valid_out[k]         <= 1'b0;
            end
`endif
            else begin
              valid_out[k] <= 1'b0;
              err_out      <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule
